// File: rtl/seq_scan_arbiter.sv
// Round-robin arbiter in front of one shared bit-serial pattern matcher.
// A granted word is shifted MSB-first, matches are counted, and the count is returned with its channel.
module seq_scan_arbiter #(
  parameter int NCH = 4,
  parameter int W   = 8,
  parameter int CW  = $clog2(W) + 1,
  parameter int IW  = $clog2(NCH)
) (
  input  logic             c,
  input  logic             r,
  input  logic [NCH-1:0]   req_valid,
  input  logic [NCH*W-1:0] req_data,
  output logic [NCH-1:0]   req_ready,
  input  logic [7:0]       cfg_pat,
  input  logic [3:0]       cfg_len,
  input  logic             cfg_ovl,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [IW-1:0]    res_ch,
  output logic [CW-1:0]    res_count,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, REPORT} state_t;

  state_t        state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] grant;
  logic          grant_ok;
  logic [W-1:0]  sreg;
  logic [7:0]    hist;
  logic [7:0]    hist_next;
  logic [7:0]    pat_q;
  logic [3:0]    len_q;
  logic [3:0]    len_eff;
  logic [7:0]    len_mask;
  logic          ovl_q;
  logic [CW-1:0] bcnt;
  logic [CW-1:0] bcnt_next;
  logic [CW-1:0] slm;
  logic [CW-1:0] slm_next;
  logic          match;

  // First valid channel at or above ptr, wrapping modulo NCH.
  always_comb begin
    int idx;
    // NOTE: every always_comb output gets a default before any branch, otherwise a latch is inferred.
    grant_ok = 1'b0;
    grant    = '0;
    idx      = 0;
    for (int i = 0; i < NCH; i++) begin
      idx = (int'(ptr) + i) % NCH;
      if (!grant_ok && req_valid[idx]) begin
        grant_ok = 1'b1;
        grant    = IW'(idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && grant_ok) req_ready[grant] = 1'b1;
  end

  assign len_eff   = (cfg_len == 4'd0) ? 4'd1 : ((cfg_len > 4'd8) ? 4'd8 : cfg_len);
  assign hist_next = {hist[6:0], sreg[W-1]};
  assign bcnt_next = bcnt + CW'(1);
  assign slm_next  = slm + CW'(1);
  assign len_mask  = 8'hFF >> (4'd8 - len_q);

  // slm counts bits since the last match (or word start), so it gates non-overlapping matches.
  assign match = (((hist_next ^ pat_q) & len_mask) == 8'h00)
              && (int'(bcnt_next) >= int'(len_q))
              && (ovl_q || (int'(slm_next) >= int'(len_q)));

  always_ff @(posedge c) begin
    if (r) begin
      state     <= IDLE;
      ptr       <= '0;
      res_ch    <= '0;
      res_count <= '0;
      res_valid <= 1'b0;
      busy      <= 1'b0;
      sreg      <= '0;
      hist      <= '0;
      pat_q     <= '0;
      len_q     <= 4'd1;
      ovl_q     <= 1'b0;
      bcnt      <= '0;
      slm       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_ok) begin
            sreg      <= req_data[int'(grant)*W +: W];
            res_ch    <= grant;
            pat_q     <= cfg_pat;
            len_q     <= len_eff;
            ovl_q     <= cfg_ovl;
            hist      <= '0;
            bcnt      <= '0;
            slm       <= '0;
            res_count <= '0;
            ptr       <= IW'((int'(grant) + 1) % NCH);
            busy      <= 1'b1;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          sreg <= sreg << 1;
          hist <= hist_next;
          bcnt <= bcnt_next;
          if (match) begin
            res_count <= res_count + CW'(1);
            slm       <= '0;
          end else begin
            slm <= slm_next;
          end
          if (bcnt_next == CW'(W)) begin
            res_valid <= 1'b1;
            state     <= REPORT;
          end
        end
        REPORT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_scan_arbiter.sv
// Self-checking bench for seq_scan_arbiter: directed cases, round-robin order, backpressure,
// reset mid-word and randomized words against a window-scanning reference model.
module tb_seq_scan_arbiter;
  localparam int NCH = 4;
  localparam int W   = 8;
  localparam int CW  = $clog2(W) + 1;
  localparam int IW  = $clog2(NCH);

  logic             c = 1'b0;
  logic             r;
  logic [NCH-1:0]   req_valid;
  logic [NCH*W-1:0] req_data;
  logic [NCH-1:0]   req_ready;
  logic [7:0]       cfg_pat;
  logic [3:0]       cfg_len;
  logic             cfg_ovl;
  logic             res_valid;
  logic             res_ready;
  logic [IW-1:0]    res_ch;
  logic [CW-1:0]    res_count;
  logic             busy;

  int checks = 0;
  int errors = 0;

  seq_scan_arbiter #(.NCH(NCH), .W(W)) dut (
    .c(c), .r(r), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .cfg_pat(cfg_pat), .cfg_len(cfg_len), .cfg_ovl(cfg_ovl),
    .res_valid(res_valid), .res_ready(res_ready), .res_ch(res_ch),
    .res_count(res_count), .busy(busy)
  );

  always #5 c = ~c;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scan every window of L arrival-ordered bits; a hit counts unless non-overlap forbids it.
  function automatic int ref_count(input logic [W-1:0] word, input logic [7:0] pat,
                                   input logic [3:0] len, input logic ovl);
    int L, cnt, last;
    bit ok;
    L    = (len == 4'd0) ? 1 : ((len > 4'd8) ? 8 : int'(len));
    cnt  = 0;
    last = -1;
    for (int i = L - 1; i < W; i++) begin
      ok = 1'b1;
      for (int j = 0; j < L; j++)
        if (word[W-1-(i-L+1+j)] !== pat[L-1-j]) ok = 1'b0;
      if (ok && (ovl || (i - last) >= L)) begin
        cnt++;
        last = i;
      end
    end
    return cnt;
  endfunction

  // Waits for res_valid at negedges; n = number of negedges since the accept edge.
  task automatic wait_result(output int n);
    n = 0;
    while (!res_valid && n < 4 * W) begin
      @(negedge c);
      n++;
    end
  endtask

  task automatic do_word(input int ch, input logic [W-1:0] word, input logic [7:0] pat,
                         input logic [3:0] len, input logic ovl, input int stall, input string tag);
    int n, exp, pch, exp2;
    logic [IW-1:0] ch_hold;
    logic [CW-1:0] cnt_hold;
    exp = ref_count(word, pat, len, ovl);
    @(negedge c);
    req_valid = '0;
    req_valid[ch] = 1'b1;
    req_data[ch*W +: W] = word;
    cfg_pat = pat;
    cfg_len = len;
    cfg_ovl = ovl;
    res_ready = (stall == 0);
    #1 check({tag, "_ready"}, 32'(req_ready), 32'(1) << ch);
    @(posedge c);
    #1;
    req_valid = '0;
    req_data  = (NCH*W)'($urandom);
    n = 0;
    while (!res_valid && n < 4 * W) begin
      cfg_pat = 8'($urandom);
      cfg_len = 4'($urandom);
      cfg_ovl = 1'($urandom);
      @(negedge c);
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(W + 1));
    check({tag, "_count"}, 32'(res_count), 32'(exp));
    check({tag, "_ch"}, 32'(res_ch), 32'(ch));
    if (stall == 0) begin
      @(negedge c);
      check({tag, "_valid_drop"}, 32'(res_valid), 32'(0));
    end else begin
      pch      = (ch + 1) % NCH;
      ch_hold  = res_ch;
      cnt_hold = res_count;
      cfg_pat  = 8'h05;
      cfg_len  = 4'd3;
      cfg_ovl  = 1'b1;
      exp2     = ref_count(8'hAA, 8'h05, 4'd3, 1'b1);
      req_valid[pch] = 1'b1;
      req_data[pch*W +: W] = 8'hAA;
      for (int s = 0; s < stall; s++) begin
        @(negedge c);
        check({tag, "_hold_valid"}, 32'(res_valid), 32'(1));
        check({tag, "_hold_ch"}, 32'(res_ch), 32'(ch_hold));
        check({tag, "_hold_count"}, 32'(res_count), 32'(cnt_hold));
        check({tag, "_hold_ready"}, 32'(req_ready), 32'(0));
      end
      res_ready = 1'b1;
      @(negedge c);
      check({tag, "_next_grant"}, 32'(req_ready), 32'(1) << pch);
      @(posedge c);
      #1 req_valid = '0;
      wait_result(n);
      check({tag, "_next_latency"}, 32'(n), 32'(W + 1));
      check({tag, "_next_count"}, 32'(res_count), 32'(exp2));
      check({tag, "_next_ch"}, 32'(res_ch), 32'(pch));
      @(negedge c);
    end
  endtask

  initial begin
    int rr_ptr, got, exp_g, n;
    bit seen;
    logic [NCH-1:0] rr_mask;
    r = 1'b1;
    req_valid = '0;
    req_data  = '0;
    cfg_pat   = '0;
    cfg_len   = '0;
    cfg_ovl   = 1'b0;
    res_ready = 1'b1;
    repeat (3) @(posedge c);
    @(negedge c);
    check("rst_valid", 32'(res_valid), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_ch", 32'(res_ch), 32'(0));
    check("rst_count", 32'(res_count), 32'(0));
    check("rst_ready", 32'(req_ready), 32'(0));
    r = 1'b0;

    do_word(0, 8'b0110_1100, 8'h06, 4'd4, 1'b1, 0, "ovl0110");
    do_word(0, 8'b0110_1100, 8'h06, 4'd4, 1'b0, 0, "novl0110");
    do_word(1, 8'hFF, 8'h03, 4'd2, 1'b1, 0, "dense_ovl");
    do_word(2, 8'hFF, 8'h03, 4'd2, 1'b0, 0, "dense_novl");
    do_word(3, 8'hFF, 8'h01, 4'd0, 1'b1, 0, "dense_len0");
    do_word(1, 8'hA5, 8'hA5, 4'd15, 1'b0, 0, "len_clamp8");

    // Round-robin with channels 0 and 2 held valid from a fresh reset.
    @(negedge c);
    r = 1'b1;
    @(negedge c);
    r = 1'b0;
    rr_mask   = 4'b0101;
    req_valid = rr_mask;
    req_data  = (NCH*W)'($urandom);
    rr_ptr = 0;
    got    = 0;
    for (int cyc = 0; cyc < 100 && got < 4; cyc++) begin
      if (cyc > 0) @(negedge c);
      #1;
      if (req_ready != '0) begin
        exp_g = rr_ptr;
        for (int k = 0; k < NCH; k++)
          if (rr_mask[(rr_ptr + k) % NCH]) begin
            exp_g = (rr_ptr + k) % NCH;
            break;
          end
        check("rr_grant", 32'(req_ready), 32'(1) << exp_g);
        check("rr_idle", 32'(busy), 32'(0));
        rr_ptr = (exp_g + 1) % NCH;
        got++;
      end else if (busy) begin
        check("rr_ready_busy", 32'(req_ready), 32'(0));
      end
    end
    check("rr_grants", 32'(got), 32'(4));
    @(posedge c);
    #1 req_valid = '0;
    wait_result(n);
    @(negedge c);

    do_word(1, 8'h3C, 8'h0F, 4'd4, 1'b1, 5, "bp");

    // Reset during the 4th SHIFT cycle of a channel-2 word.
    @(negedge c);
    req_valid = 4'b0100;
    req_data[2*W +: W] = 8'hFF;
    cfg_pat = 8'h01;
    cfg_len = 4'd1;
    @(posedge c);
    #1 req_valid = '0;
    repeat (3) @(posedge c);
    @(negedge c);
    r = 1'b1;
    @(negedge c);
    r = 1'b0;
    check("midrst_busy", 32'(busy), 32'(0));
    check("midrst_valid", 32'(res_valid), 32'(0));
    seen = 1'b0;
    for (int k = 0; k < W + 4; k++) begin
      @(negedge c);
      if (res_valid) seen = 1'b1;
    end
    check("midrst_no_result", 32'(seen), 32'(0));
    req_valid = 4'b1111;
    #1 check("midrst_ptr0", 32'(req_ready), 32'(1));
    @(posedge c);
    #1 req_valid = '0;
    wait_result(n);
    check("midrst_next_ch", 32'(res_ch), 32'(0));
    @(negedge c);

    for (int t = 0; t < 24; t++)
      do_word($urandom_range(0, NCH - 1), W'($urandom), 8'($urandom),
              4'($urandom_range(0, 15)), 1'($urandom), 0, "rand");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
